mem_arbiter: RTL and testbench

Two-port arbiter sharing one single-ported unified memory between the pipelined core's fetch port (F stage) and its data port (M stage). It replaces the separate instruction and data memories with one backing store that has a variable-latency req/ack handshake. Each transaction is serialised through a three-phase FSM. Data accesses have priority, and a bounded-starvation counter keeps fetch progressing. The block drives stall signals back to the pipeline.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/arb_streak_ctr.sv | 32 +++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Purpose: shared types and constants for the fetch/data memory arbiter.
// Latency: not applicable (types and constants only).
// Backpressure: not applicable.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Wide enough for the largest allowed data-streak limit (15).
    localparam int STREAK_W = 4;

endpackage

// File: rtl/arb_streak_ctr.sv
// Purpose: saturating count of consecutive data grants made while a fetch waits.
// Latency: the count updates on the clock edge after inc/clr; sat_hit is combinational from the count.
// Backpressure: none; inc is ignored once the count reaches sat, and clr wins over inc.
//
// Ports: clk, reset (sync, active-low), inc, clr, sat (saturation value),
//        sat_hit (count == sat).
module arb_streak_ctr
    import arb_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    input  logic                clr,
    input  logic [STREAK_W-1:0] sat,
    output logic                sat_hit
);

    logic [STREAK_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt < sat)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sat_hit = (cnt == sat);

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: shares one single-ported memory between the fetch port and the data port, giving data priority
//          while bounding how long fetch can be starved.
// Latency: a request seen in IDLE raises mem_req on the next cycle. The valid pulse comes one cycle after
//          mem_ack, and the next arbitration happens one cycle after that (at least 3 cycles per access).
// Backpressure: StallF/StallM stay high while a request waits for its valid pulse, and the memory holds the
//          block in BUSY until it acks.
//
// Ports:
//   clk, reset                                  clock and synchronous active-low reset
//   IReqF, PCF -> InstrF, IValidF, StallF        fetch port
//   DReqM, MemWriteM, DataAdrM, WriteDataM
//     -> ReadDataM, DValidM, StallM              data port
//   mem_req, mem_we, mem_addr, mem_wdata,
//     mem_rdata, mem_ack                         shared memory req/ack port
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          IReqF,
    input  logic [AW-1:0] PCF,
    output logic [DW-1:0] InstrF,
    output logic          IValidF,
    output logic          StallF,

    input  logic          DReqM,
    input  logic          MemWriteM,
    input  logic [AW-1:0] DataAdrM,
    input  logic [DW-1:0] WriteDataM,
    output logic [DW-1:0] ReadDataM,
    output logic          DValidM,
    output logic          StallM,

    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam logic [STREAK_W-1:0] SAT = STREAK_W'(MAX_DSTREAK);

    arb_state_t    state;
    owner_t        owner;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          lat_we;

    logic sat_hit;
    logic grant_d;
    logic grant_i;
    logic streak_inc;
    logic streak_clr;

    // Data wins whenever it asks, unless fetch is also waiting and has already
    // watched MAX_DSTREAK data grants go by.
    always_comb begin
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        streak_inc = 1'b0;
        streak_clr = 1'b0;
        if (state == IDLE) begin
            grant_d = DReqM && !(IReqF && sat_hit);
            grant_i = IReqF && !grant_d;
        end
        streak_inc = grant_d && IReqF;
        streak_clr = grant_i || (grant_d && !IReqF);
    end

    arb_streak_ctr u_streak (
        .clk     (clk),
        .reset   (reset),
        .inc     (streak_inc),
        .clr     (streak_clr),
        .sat     (SAT),
        .sat_hit (sat_hit)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= OWN_I;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            mem_req   <= 1'b0;
            InstrF    <= '0;
            ReadDataM <= '0;
            IValidF   <= 1'b0;
            DValidM   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    IValidF <= 1'b0;
                    DValidM <= 1'b0;
                    if (grant_d) begin
                        owner     <= OWN_D;
                        lat_addr  <= DataAdrM;
                        lat_wdata <= WriteDataM;
                        lat_we    <= MemWriteM;
                        mem_req   <= 1'b1;
                        state     <= BUSY;
                    end else if (grant_i) begin
                        // A fetch carries no store data, so mem_wdata keeps its last value.
                        owner     <= OWN_I;
                        lat_addr  <= PCF;
                        lat_we    <= 1'b0;
                        mem_req   <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (owner == OWN_I) begin
                            InstrF <= mem_rdata;
                        end else if (!lat_we) begin
                            ReadDataM <= mem_rdata;
                        end
                        IValidF <= (owner == OWN_I);
                        DValidM <= (owner == OWN_D);
                        state   <= DONE;
                    end
                end
                DONE: begin
                    IValidF <= 1'b0;
                    DValidM <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    mem_req <= 1'b0;
                    IValidF <= 1'b0;
                    DValidM <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign mem_we    = mem_req && lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    // These depend only on the request inputs and registered valids, so the
    // pipeline cannot form a loop back into the arbitration.
    assign StallF = IReqF && !IValidF;
    assign StallM = DReqM && !DValidM;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        IReqF;
    logic [31:0] PCF;
    logic [31:0] InstrF;
    logic        IValidF;
    logic        StallF;
    logic        DReqM;
    logic        MemWriteM;
    logic [31:0] DataAdrM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        DValidM;
    logic        StallM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32), .MAX_DSTREAK(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .IReqF      (IReqF),
        .PCF        (PCF),
        .InstrF     (InstrF),
        .IValidF    (IValidF),
        .StallF     (StallF),
        .DReqM      (DReqM),
        .MemWriteM  (MemWriteM),
        .DataAdrM   (DataAdrM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .DValidM    (DValidM),
        .StallM     (StallM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    typedef struct {
        bit          is_d;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_assert    = 0;
    int          n_fail      = 0;
    int          ack_delay   = 1;
    int          busy_cnt    = 0;
    bit          force_ack   = 1'b0;
    bit          chk_stall   = 1'b0;
    logic [31:0] exp_rd_last = 32'h0;

    function automatic logic [31:0] rdfn(input logic [31:0] a);
        if (a == 32'h40) return 32'hE3A0_1005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_i(input logic [31:0] addr);
        exp_t e;
        e.is_d = 1'b0;
        e.data = rdfn(addr);
        sb.push_back(e);
    endtask

    task automatic push_d(input logic [31:0] addr, input bit we);
        exp_t e;
        if (!we) exp_rd_last = rdfn(addr);
        e.is_d = 1'b1;
        e.data = exp_rd_last;
        sb.push_back(e);
    endtask

    // One clock: sample #1 after the edge, check valids against the scoreboard,
    // then act as the memory for the cycle that just started.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (chk_stall) begin
            chk("StallF", {31'b0, StallF}, {31'b0, !IValidF});
            chk("StallM", {31'b0, StallM}, {31'b0, !DValidM});
        end
        if (IValidF === 1'b1 || DValidM === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", {30'b0, IValidF, DValidM}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("valid_owner", {30'b0, IValidF, DValidM}, e.is_d ? 32'h1 : 32'h2);
                if (e.is_d) chk("ReadDataM", ReadDataM, e.data);
                else        chk("InstrF", InstrF, e.data);
            end
        end
        if (mem_req === 1'b1) begin
            busy_cnt++;
            mem_ack   = (busy_cnt == ack_delay) || force_ack;
            mem_rdata = rdfn(mem_addr);
        end else begin
            busy_cnt = 0;
            mem_ack  = force_ack;
        end
    endtask

    // Step until nvalid valid pulses, watching the memory bus while mem_req is high.
    task automatic run(input string tag, input int nvalid, input int bound, input int perturb,
                       input bit chk_bus, input logic [31:0] exp_addr, input logic exp_we,
                       output int ticks, output int reqc, output bit bus_ok);
        int seen;
        seen   = 0;
        ticks  = 0;
        reqc   = 0;
        bus_ok = 1'b1;
        while (seen < nvalid && ticks < bound) begin
            tick();
            ticks++;
            if (mem_req === 1'b1) begin
                reqc++;
                if (chk_bus && (mem_addr !== exp_addr || mem_we !== exp_we)) bus_ok = 1'b0;
            end
            if (IValidF === 1'b1 || DValidM === 1'b1) seen++;
            if (ticks == perturb) begin
                PCF        = 32'h000B_EEF0;
                DataAdrM   = 32'h000D_EAD0;
                WriteDataM = 32'h1234_5678;
            end
        end
        chk({tag, "_valids_seen"}, seen, nvalid);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_mem_req"},   {31'b0, mem_req}, 32'h0);
        chk({tag, "_mem_we"},    {31'b0, mem_we},  32'h0);
        chk({tag, "_mem_addr"},  mem_addr,  32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_IValidF"},   {31'b0, IValidF}, 32'h0);
        chk({tag, "_DValidM"},   {31'b0, DValidM}, 32'h0);
        chk({tag, "_InstrF"},    InstrF,    32'h0);
        chk({tag, "_ReadDataM"}, ReadDataM, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ticks;
        int reqc;
        int gap;
        bit bus_ok;

        reset      = 1'b0;
        IReqF      = 1'b0;
        PCF        = 32'h0;
        DReqM      = 1'b0;
        MemWriteM  = 1'b0;
        DataAdrM   = 32'h0;
        WriteDataM = 32'h0;
        mem_rdata  = 32'h0;
        mem_ack    = 1'b0;

        repeat (3) tick();
        reset_checks("por");
        reset = 1'b1;
        tick();

        // Single fetch, ack in the first BUSY cycle.
        PCF   = 32'h0000_0040;
        IReqF = 1'b1;
        push_i(32'h40);
        ack_delay = 1;
        run("t1", 1, 20, 0, 1'b1, 32'h40, 1'b0, ticks, reqc, bus_ok);
        IReqF = 1'b0;
        chk("t1_latency", ticks, 2);
        chk("t1_req_cycles", reqc, 1);
        chk("t1_bus", {31'b0, bus_ok}, 32'h1);
        tick();
        tick();

        // Data read at 0x80; request inputs change while BUSY.
        DataAdrM  = 32'h80;
        MemWriteM = 1'b0;
        DReqM     = 1'b1;
        push_d(32'h80, 1'b0);
        ack_delay = 3;
        run("t4", 1, 20, 2, 1'b1, 32'h80, 1'b0, ticks, reqc, bus_ok);
        DReqM = 1'b0;
        chk("t4_latency", ticks, 4);
        chk("t4_req_cycles", reqc, 3);
        chk("t4_addr_stable", {31'b0, bus_ok}, 32'h1);
        tick();
        tick();

        // Data write, ack delayed 3 cycles; ReadDataM must keep the earlier load.
        DataAdrM   = 32'h64;
        WriteDataM = 32'h7;
        MemWriteM  = 1'b1;
        DReqM      = 1'b1;
        push_d(32'h64, 1'b1);
        ack_delay = 3;
        run("t2", 1, 20, 0, 1'b1, 32'h64, 1'b1, ticks, reqc, bus_ok);
        DReqM     = 1'b0;
        MemWriteM = 1'b0;
        chk("t2_latency", ticks, 4);
        chk("t2_req_cycles", reqc, 3);
        chk("t2_bus_we_addr", {31'b0, bus_ok}, 32'h1);
        chk("t2_mem_wdata", mem_wdata, 32'h7);
        tick();
        tick();

        // Both ports held high: D D D D I, twice.
        PCF      = 32'h200;
        DataAdrM = 32'h100;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) push_d(32'h100, 1'b0);
            push_i(32'h200);
        end
        ack_delay = 1;
        IReqF     = 1'b1;
        DReqM     = 1'b1;
        chk_stall = 1'b1;
        run("t3", 10, 100, 0, 1'b0, 32'h0, 1'b0, ticks, reqc, bus_ok);
        chk_stall = 1'b0;
        IReqF     = 1'b0;
        DReqM     = 1'b0;
        chk("t3_cycles", ticks, 29);
        tick();
        tick();

        // Reset in BUSY of the 4th consecutive data grant (streak at its limit), then a late ack.
        for (int k = 0; k < 3; k++) push_d(32'h100, 1'b0);
        IReqF = 1'b1;
        DReqM = 1'b1;
        run("t5a", 3, 40, 0, 1'b0, 32'h0, 1'b0, ticks, reqc, bus_ok);
        ack_delay = 100;
        tick();
        tick();
        chk("t5_busy_before_reset", {31'b0, mem_req}, 32'h1);
        reset = 1'b0;
        IReqF = 1'b0;
        DReqM = 1'b0;
        tick();
        reset_checks("t5_rst");
        exp_rd_last = 32'h0;
        reset     = 1'b1;
        force_ack = 1'b1;
        tick();
        tick();
        force_ack = 1'b0;
        ack_delay = 1;
        tick();
        chk("t5_late_ack_mem_req", {31'b0, mem_req}, 32'h0);
        chk("t5_late_ack_ReadDataM", ReadDataM, 32'h0);
        // A cleared streak lets data win over a waiting fetch again.
        push_d(32'h100, 1'b0);
        IReqF = 1'b1;
        DReqM = 1'b1;
        run("t5b", 1, 20, 0, 1'b0, 32'h0, 1'b0, ticks, reqc, bus_ok);
        IReqF = 1'b0;
        DReqM = 1'b0;
        tick();
        tick();

        // DReqM held through DValidM starts a second data transaction.
        DataAdrM  = 32'hC0;
        MemWriteM = 1'b0;
        DReqM     = 1'b1;
        push_d(32'hC0, 1'b0);
        push_d(32'hC0, 1'b0);
        run("t6a", 1, 20, 0, 1'b0, 32'h0, 1'b0, ticks, reqc, bus_ok);
        gap = 0;
        do begin
            tick();
            gap++;
        end while (mem_req !== 1'b1 && gap < 10);
        chk("t6_req_gap", gap, 2);
        run("t6b", 1, 20, 0, 1'b0, 32'h0, 1'b0, ticks, reqc, bus_ok);
        DReqM = 1'b0;
        chk("t6b_latency", ticks, 1);
        repeat (3) tick();
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
